// File: rtl/dpll_lock_monitor_pkg.sv
// ---------------------------------------------------------------------------
// dpll_pkg
// Shared types and defaults for the DPLL lock monitor.
//   lock_state_e     : lock FSM encoding exposed on lock_state
//   DPLL_LOCK_CNT    : default quiet run needed to declare lock
//   DPLL_UNLOCK_CNT  : default error run needed to drop lock
// ---------------------------------------------------------------------------
package dpll_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2,
    HOLD     = 2'd3
  } lock_state_e;

  localparam int DPLL_LOCK_CNT   = 64;
  localparam int DPLL_UNLOCK_CNT = 4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dpll_lock_monitor_if.sv
// ---------------------------------------------------------------------------
// dpll_lock_if
// Bundle between the PFD side of the DPLL top and the lock monitor.
//   up/down     : PFD pulses, synchronous to the PLL clock
//   slip_clr    : synchronous clear of the lock-loss counter
//   scan_en/in  : scan shift control and serial input
//   scan_out    : scan serial output
//   locked      : qualified lock indicator
//   lock_state  : FSM state encoding
//   lock_lost   : one-cycle pulse when lock drops
//   slip_count  : saturating lock-loss count (SLIP_W bits)
// master = driver side (DPLL top / bench), slave = lock monitor.
// ---------------------------------------------------------------------------
interface dpll_lock_if #(
  parameter int SLIP_W = 8
);
  logic              up;
  logic              down;
  logic              slip_clr;
  logic              scan_en;
  logic              scan_in;
  logic              scan_out;
  logic              locked;
  logic [1:0]        lock_state;
  logic              lock_lost;
  logic [SLIP_W-1:0] slip_count;

  modport master (
    output up, down, slip_clr, scan_en, scan_in,
    input  scan_out, locked, lock_state, lock_lost, slip_count
  );

  modport slave (
    input  up, down, slip_clr, scan_en, scan_in,
    output scan_out, locked, lock_state, lock_lost, slip_count
  );
endinterface

// File: rtl/dpll_lock_monitor_sat_counter.sv
// ---------------------------------------------------------------------------
// dpll_sat_counter
// W-bit up counter that sticks at all-ones, with a clear that beats the
// increment. While scan_en is high it becomes a shift register:
// scan_in -> count[0] -> ... -> count[W-1] -> scan_out.
//   clk, rst_n : clock, async active-low reset
//   inc, clr   : functional increment / clear (ignored while scanning)
//   scan_en    : shift enable
//   scan_in    : serial in, scan_out : serial out
//   count      : current value
// ---------------------------------------------------------------------------
module dpll_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  input  logic         scan_en,
  input  logic         scan_in,
  output logic         scan_out,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = '1;

  // {count, scan_in} works for W == 1 as well as wider counters
  logic [W:0] shifted;
  assign shifted  = {count, scan_in};
  assign scan_out = count[W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   count <= '0;
    else if (scan_en)             count <= shifted[W-1:0];
    else if (clr)                 count <= '0;
    else if (inc && count != MAX) count <= count + W'(1);
  end

endmodule

// File: rtl/dpll_lock_monitor.sv
// ---------------------------------------------------------------------------
// dpll_lock_monitor
// Lock qualifier placed after the PFD. Lock is declared after LOCK_CNT
// consecutive quiet samples (no up, no down) and dropped only after
// UNLOCK_CNT consecutive error samples. Each drop pulses lock_lost and bumps
// a saturating slip counter. All state flops join one scan chain:
//   scan_in -> locked -> state[0] -> state[1] -> cnt[0..CNT_W-1]
//           -> slip_count[0..SLIP_W-1] -> lock_lost -> scan_out
// Ports:
//   clk   : PLL-domain clock, rising edge
//   rst_n : async active-low reset
//   bus   : dpll_lock_if slave (PFD inputs, scan, lock status outputs);
//           the interface SLIP_W must match this module's SLIP_W
// lock_lost may toggle while shifting; consumers gate it with !scan_en.
// ---------------------------------------------------------------------------
module dpll_lock_monitor
  import dpll_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int LOCK_CNT   = DPLL_LOCK_CNT,
  parameter int UNLOCK_CNT = DPLL_UNLOCK_CNT,
  parameter int SLIP_W     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  dpll_lock_if.slave  bus
);

  if (LOCK_CNT < 2) begin : g_chk_lock
    $error("dpll_lock_monitor: LOCK_CNT must be >= 2");
  end
  if (UNLOCK_CNT < 2) begin : g_chk_unlock
    $error("dpll_lock_monitor: UNLOCK_CNT must be >= 2");
  end
  if ((2 ** CNT_W) <= (max2(LOCK_CNT, UNLOCK_CNT) - 1)) begin : g_chk_cnt_w
    $error("dpll_lock_monitor: CNT_W too narrow for LOCK_CNT/UNLOCK_CNT");
  end

  localparam logic [1:0] ST_UNLOCKED = UNLOCKED;
  localparam logic [1:0] ST_ACQUIRE  = ACQUIRE;
  localparam logic [1:0] ST_LOCKED   = LOCKED;
  localparam logic [1:0] ST_HOLD     = HOLD;

  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_CNT - 1);
  localparam logic [CNT_W-1:0] UNLOCK_LAST = CNT_W'(UNLOCK_CNT - 1);

  logic [1:0]        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              locked, lock_lost;
  logic              lost_nxt;
  logic              err;
  logic [CNT_W:0]    cnt_shift;
  logic              slip_so;
  logic [SLIP_W-1:0] slip_count;

  assign err       = bus.up | bus.down;
  assign cnt_shift = {cnt, state[1]};

  // One run-length counter serves both directions: it counts quiet samples
  // in ACQUIRE and error samples in HOLD, and idles at 0 elsewhere.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lost_nxt  = 1'b0;
    case (state)
      ST_UNLOCKED: begin
        if (!err) begin
          state_nxt = ST_ACQUIRE;
          cnt_nxt   = CNT_W'(1);
        end
      end
      ST_ACQUIRE: begin
        if (err) begin
          state_nxt = ST_UNLOCKED;
          cnt_nxt   = '0;
        end else if (cnt == LOCK_LAST) begin
          state_nxt = ST_LOCKED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      ST_LOCKED: begin
        if (err) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = CNT_W'(1);
        end
      end
      default: begin // ST_HOLD
        if (!err) begin
          state_nxt = ST_LOCKED;
          cnt_nxt   = '0;
        end else if (cnt == UNLOCK_LAST) begin
          state_nxt = ST_UNLOCKED;
          cnt_nxt   = '0;
          lost_nxt  = 1'b1;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_UNLOCKED;
      cnt       <= '0;
      locked    <= 1'b0;
      lock_lost <= 1'b0;
    end else if (bus.scan_en) begin
      locked    <= bus.scan_in;
      state     <= {state[0], locked};
      cnt       <= cnt_shift[CNT_W-1:0];
      lock_lost <= slip_so;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      // registered alongside the state so it moves on the same edge
      locked    <= (state_nxt == ST_LOCKED) || (state_nxt == ST_HOLD);
      lock_lost <= lost_nxt;
    end
  end

  dpll_sat_counter #(
    .W (SLIP_W)
  ) u_slip (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (lost_nxt & ~bus.scan_en),
    .clr      (bus.slip_clr & ~bus.scan_en),
    .scan_en  (bus.scan_en),
    .scan_in  (cnt[CNT_W-1]),
    .scan_out (slip_so),
    .count    (slip_count)
  );

  assign bus.locked     = locked;
  assign bus.lock_state = state;
  assign bus.lock_lost  = lock_lost;
  assign bus.slip_count = slip_count;
  assign bus.scan_out   = lock_lost;

endmodule

// File: doc/dpll_lock_monitor.md
Name: dpll_lock_monitor

Overview:
Parametrised successor to the single-flop DPLL lock indicator. It qualifies lock by requiring LOCK_CNT consecutive quiet PFD cycles (no up and no down). It drops lock only after UNLOCK_CNT consecutive error cycles (hysteresis), counts lock losses, and joins the DPLL scan chain. It sits after the PFD in the DPLL top and replaces the inline lock flop there.

Parameters:
CNT_W, 8, width of the shared run-length counter; must hold max(LOCK_CNT, UNLOCK_CNT)-1
LOCK_CNT, 64, consecutive quiet cycles needed to declare lock; must be >= 2
UNLOCK_CNT, 4, consecutive error cycles needed to drop lock; must be >= 2
SLIP_W, 8, width of the saturating lock-loss counter

Ports:
clk  in  1  PLL-domain clock; all flops on the rising edge
rst_n  in  1  asynchronous active-low reset
up  in  1  PFD up, synchronous to clk
down  in  1  PFD down, synchronous to clk
slip_clr  in  1  synchronous clear of slip_count
scan_en  in  1  scan shift enable
scan_in  in  1  scan serial input
scan_out  out  1  scan serial output
locked  out  1  qualified lock indicator
lock_state  out  2  current FSM state encoding
lock_lost  out  1  one-cycle pulse when lock is dropped
slip_count  out  SLIP_W  number of lock losses since reset or clear, saturating

Behaviour:
- One clock, clk. Reset is asynchronous, active-low on rst_n. While reset is asserted:
  - state = UNLOCKED, cnt = 0, locked = 0, lock_lost = 0, slip_count = 0, scan_out = 0.
- err = up | down. It is sampled every rising edge. All outputs come from registers; there is no combinational path from input to output.
- State encoding: UNLOCKED = 0, ACQUIRE = 1, LOCKED = 2, HOLD = 3.
- UNLOCKED: on a quiet sample, cnt <= 1 and go to ACQUIRE. On an error sample, stay.
- ACQUIRE:
  - Error sample: go to UNLOCKED, cnt <= 0.
  - Quiet sample with cnt == LOCK_CNT-1: go to LOCKED, cnt <= 0.
  - Otherwise: cnt++.
- LOCKED: on an error sample, cnt <= 1 and go to HOLD. On a quiet sample, stay.
- HOLD:
  - Quiet sample: go to LOCKED, cnt <= 0. Errors must be consecutive to count.
  - Error sample with cnt == UNLOCK_CNT-1: go to UNLOCKED, cnt <= 0, lock_lost <= 1 for exactly one cycle, slip_count++.
  - Otherwise: cnt++.
- Latency: locked is a flop, loaded in the same edge as the state transition.
  - locked = 1 in LOCKED and HOLD, 0 otherwise.
  - locked rises at the edge that samples the LOCK_CNT-th consecutive quiet cycle.
  - locked falls at the edge that samples the UNLOCK_CNT-th consecutive error cycle.
- slip_count:
  - Saturates at 2^SLIP_W-1; it never wraps.
  - slip_clr clears it to 0. If slip_clr and a lock loss occur in the same cycle, the clear wins (result 0). lock_lost still pulses.
- Scan (scan_en = 1):
  - The functional update is suppressed. All state flops form one shift register, in this order: scan_in -> locked -> state[0] -> state[1] -> cnt[0..CNT_W-1] -> slip_count[0..SLIP_W-1] -> lock_lost -> scan_out.
  - Chain length is 4 + CNT_W + SLIP_W; scan_out is the lock_lost flop.
  - up, down and slip_clr are ignored while scanning.
  - lock_lost may toggle during shift; downstream logic must gate it with !scan_en.
- Reset mid-operation, in any state: outputs return to their reset values immediately, without waiting for a clock edge.
- Elaboration-time checks fail on: LOCK_CNT < 2, UNLOCK_CNT < 2, or 2^CNT_W <= max(LOCK_CNT, UNLOCK_CNT)-1.

Decomposition:
- Package dpll_pkg holds:
  - typedef enum logic [1:0] lock_state_e {UNLOCKED, ACQUIRE, LOCKED, HOLD};
  - the default constants DPLL_LOCK_CNT and DPLL_UNLOCK_CNT.
- One sub-module, dpll_sat_counter: a parametrised SLIP_W saturating counter with inc, clr (clr priority), scan_en, scan_in and scan_out. It is reused for slip_count.
- FSM and run-length counter stay in dpll_lock_monitor.

Test Plan:
- Defaults; release reset; up = down = 0 from edge 1 -> lock_state = 1 after edge 1; locked = 1 and lock_state = 2 after edge 64, not before.
- 40 quiet cycles, then up = 1 for one cycle, then quiet -> lock_state = 0 after the error edge; locked rises 64 quiet edges later.
- Locked; down = 1 for 3 cycles, then quiet -> locked stays 1, lock_state goes 3 then 2, slip_count = 0, lock_lost never pulses. Then down = 1 for 4 cycles -> locked = 0 after the 4th edge, lock_lost high for exactly 1 cycle, slip_count = 1.
- SLIP_W = 2, LOCK_CNT = 2, UNLOCK_CNT = 2; force 5 lock losses -> slip_count = 3 (saturated). Then assert slip_clr in the same cycle as a 6th loss -> slip_count = 0 and lock_lost pulses.
- scan_en = 1, shift a 20-bit pattern (defaults) while toggling up/down -> pattern appears on scan_out delayed by 20 cycles. Shift it back out and compare; FSM shows no functional change.
- In HOLD, pull rst_n low between clock edges -> locked, lock_state, slip_count and lock_lost all go to 0 before the next edge.
